// File: rtl/rx_descrambler.sv
// Per-lane Gen1/Gen2 receive descrambler: tracks ordered-set framing so COM/SKP/TS
// symbols bypass descrambling while the LFSR stays in lock-step with the far-end scrambler.
module rx_descrambler #(
    parameter int          MAXPIPEWIDTH = 32,
    parameter logic [15:0] LFSR_INIT    = 16'hFFFF
) (
    input  logic                      pclk,
    input  logic                      reset,
    input  logic                      turnOff,
    input  logic [5:0]                pipewidth,
    input  logic [MAXPIPEWIDTH-1:0]   RxData,
    input  logic [MAXPIPEWIDTH/8-1:0] RxDataK,
    input  logic                      RxDataValid,
    output logic [MAXPIPEWIDTH-1:0]   DataOut,
    output logic [MAXPIPEWIDTH/8-1:0] DataKOut,
    output logic                      DataValidOut
);

    localparam int NSYM = MAXPIPEWIDTH / 8;

    localparam logic [7:0] K_COM = 8'hBC;
    localparam logic [7:0] K_SKP = 8'h1C;
    localparam logic [7:0] K_FTS = 8'h3C;
    localparam logic [7:0] K_IDL = 8'h7C;
    localparam logic [7:0] K_EIE = 8'hFC;

    typedef enum logic [1:0] {
        ST_DATA,
        ST_OS_HDR,
        ST_OS_TS,
        ST_SKP_OS
    } state_t;

    state_t                    r_state;
    logic [15:0]               r_lfsr;
    logic [3:0]                r_os_cnt;
    logic [MAXPIPEWIDTH-1:0]   r_data_out;
    logic [NSYM-1:0]           r_k_out;
    logic                      r_valid_out;

    state_t                    w_state;
    logic [15:0]               w_lfsr;
    logic [3:0]                w_os_cnt;
    logic [MAXPIPEWIDTH-1:0]   w_data;
    logic [7:0]                w_sym;
    logic                      w_k;
    logic [23:0]               w_scr;
    logic                      w_unused;

    // Only the symbol-count bits of pipewidth matter (8/16/32 -> 1/2/4 symbols).
    assign w_unused = ^pipewidth[2:0];

    // Advance the Galois LFSR by one byte, LSB first; returns {next_lfsr, descrambled_byte}.
    function automatic logic [23:0] lfsr_byte(input logic [15:0] lfsr_in, input logic [7:0] din);
        logic [15:0] l;
        logic [7:0]  d;
        l = lfsr_in;
        for (int b = 0; b < 8; b++) begin
            d[b] = din[b] ^ l[15];
            l    = {l[14:0], 1'b0} ^ (l[15] ? 16'h0039 : 16'h0000);
        end
        return {l, d};
    endfunction

    // Symbols chain combinationally: each one sees the LFSR/state left by the previous one.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no path infers a latch.
        w_state  = r_state;
        w_lfsr   = r_lfsr;
        w_os_cnt = r_os_cnt;
        w_data   = '0;
        w_sym    = '0;
        w_k      = 1'b0;
        w_scr    = '0;
        for (int i = 0; i < NSYM; i++) begin
            if (3'(i) < pipewidth[5:3]) begin
                w_sym               = RxData[8*i +: 8];
                w_k                 = RxDataK[i];
                w_scr               = lfsr_byte(w_lfsr, w_sym);
                w_data[8*i +: 8]    = w_sym;
                if (w_k && w_sym == K_COM) begin
                    w_lfsr  = LFSR_INIT;
                    w_state = ST_OS_HDR;
                end else if (w_k && w_sym == K_SKP &&
                             (w_state == ST_OS_HDR || w_state == ST_SKP_OS)) begin
                    w_state = ST_SKP_OS;
                end else begin
                    w_lfsr = w_scr[23:8];
                    case (w_state)
                        ST_OS_HDR: begin
                            if (w_k && (w_sym == K_FTS || w_sym == K_IDL || w_sym == K_EIE)) begin
                                w_state = ST_DATA;
                            end else begin
                                // TS1/TS2: 14 more symbols follow the link field.
                                w_os_cnt = 4'd13;
                                w_state  = ST_OS_TS;
                            end
                        end
                        ST_OS_TS: begin
                            if (w_os_cnt == 4'd0) begin
                                w_state = ST_DATA;
                            end else begin
                                w_os_cnt = w_os_cnt - 4'd1;
                            end
                        end
                        default: begin
                            w_state = ST_DATA;
                            if (!w_k && !turnOff) begin
                                w_data[8*i +: 8] = w_scr[7:0];
                            end
                        end
                    endcase
                end
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            r_state     <= ST_DATA;
            r_lfsr      <= LFSR_INIT;
            r_os_cnt    <= '0;
            r_data_out  <= '0;
            r_k_out     <= '0;
            r_valid_out <= 1'b0;
        end else begin
            r_valid_out <= RxDataValid;
            if (RxDataValid) begin
                r_state    <= w_state;
                r_lfsr     <= w_lfsr;
                r_os_cnt   <= w_os_cnt;
                r_data_out <= w_data;
                r_k_out    <= RxDataK;
            end else begin
                r_data_out <= '0;
                r_k_out    <= '0;
            end
        end
    end

    assign DataOut      = r_data_out;
    assign DataKOut     = r_k_out;
    assign DataValidOut = r_valid_out;

endmodule

// File: tb/tb_rx_descrambler.sv
// Directed bench for rx_descrambler; expected bytes come from the hand-computed
// scrambler sequence after COM: FF 17 C0 14 B2 E7 02 82 72 6E 28 A6 BE 6D BF 8D BE.
module tb_rx_descrambler;

    logic        pclk;
    logic        reset;
    logic        turnOff;
    logic [5:0]  pipewidth;
    logic [31:0] RxData;
    logic [3:0]  RxDataK;
    logic        RxDataValid;
    logic [31:0] DataOut;
    logic [3:0]  DataKOut;
    logic        DataValidOut;

    int n_tests = 0;
    int n_fail  = 0;

    rx_descrambler #(
        .MAXPIPEWIDTH(32),
        .LFSR_INIT   (16'hFFFF)
    ) dut (
        .pclk        (pclk),
        .reset       (reset),
        .turnOff     (turnOff),
        .pipewidth   (pipewidth),
        .RxData      (RxData),
        .RxDataK     (RxDataK),
        .RxDataValid (RxDataValid),
        .DataOut     (DataOut),
        .DataKOut    (DataKOut),
        .DataValidOut(DataValidOut)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Inputs change on the falling edge; outputs are sampled on the next falling edge.
    task automatic drive(input logic v, input logic [31:0] d, input logic [3:0] k);
        RxDataValid = v;
        RxData      = d;
        RxDataK     = k;
        @(negedge pclk);
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        turnOff     = 1'b0;
        pipewidth   = 6'd8;
        RxDataValid = 1'b1;
        RxDataK     = 4'b0000;
        for (int c = 0; c < 2; c++) begin
            RxData = $urandom;
            @(negedge pclk);
            n_tests++;
            if (DataValidOut !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_valid[%0d] got %b want 0", c, DataValidOut);
            end
            n_tests++;
            if (DataOut !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_data[%0d] got %h want 00000000", c, DataOut);
            end
        end
        reset = 1'b0;
        drive(1'b1, 32'h00AB_CDFF, 4'b0000);
        n_tests++;
        if (DataValidOut !== 1'b1 || DataOut !== 32'h0) begin
            n_fail++;
            $display("FAIL first_after_reset got v=%b d=%h want v=1 d=00000000", DataValidOut, DataOut);
        end
        drive(1'b0, 32'h0, 4'b0000);
        n_tests++;
        if (DataValidOut !== 1'b0) begin
            n_fail++;
            $display("FAIL valid_drop got %b want 0", DataValidOut);
        end
    endtask

    task automatic test_known_pw8();
        logic [7:0] st [9] = '{8'hBC, 8'h3C, 8'h17, 8'hC0, 8'h14, 8'hB2, 8'hE7, 8'h02, 8'hD8};
        logic       kk [9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [7:0] ex [9] = '{8'hBC, 8'h3C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h5A};
        logic [23:0] junk;
        pipewidth = 6'd8;
        for (int i = 0; i < 9; i++) begin
            junk = 24'($urandom);
            drive(1'b1, {junk, st[i]}, {3'b000, kk[i]});
            n_tests++;
            if (DataValidOut !== 1'b1 || DataOut !== {24'h0, ex[i]}) begin
                n_fail++;
                $display("FAIL known[%0d] got v=%b d=%h want v=1 d=%h", i, DataValidOut, DataOut, {24'h0, ex[i]});
            end
            n_tests++;
            if (DataKOut !== {3'b000, kk[i]}) begin
                n_fail++;
                $display("FAIL known_k[%0d] got %b want %b", i, DataKOut, {3'b000, kk[i]});
            end
        end
        drive(1'b0, 32'h0, 4'b0000);
    endtask

    task automatic test_skp_pw32();
        logic [31:0] st [3] = '{32'h1C1C_1CBC, 32'h06F4_4187, 32'h8202_E7B2};
        logic [3:0]  kk [3] = '{4'b1111, 4'b0000, 4'b0000};
        logic [31:0] ex [3] = '{32'h1C1C_1CBC, 32'h1234_5678, 32'h0000_0000};
        pipewidth = 6'd32;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, st[i], kk[i]);
            n_tests++;
            if (DataOut !== ex[i] || DataKOut !== kk[i]) begin
                n_fail++;
                $display("FAIL skp[%0d] got d=%h k=%b want d=%h k=%b", i, DataOut, DataKOut, ex[i], kk[i]);
            end
        end
        drive(1'b0, 32'h0, 4'b0000);
    endtask

    task automatic test_ts1_pw16();
        pipewidth = 6'd16;
        drive(1'b1, 32'h5A5A_4ABC, 4'b0001);
        n_tests++;
        if (DataOut !== 32'h0000_4ABC || DataKOut !== 4'b0001) begin
            n_fail++;
            $display("FAIL ts_com got d=%h k=%b want d=00004abc k=0001", DataOut, DataKOut);
        end
        for (int i = 1; i < 8; i++) begin
            drive(1'b1, 32'h3333_4A4A, 4'b0000);
            n_tests++;
            if (DataOut !== 32'h0000_4A4A) begin
                n_fail++;
                $display("FAIL ts_body[%0d] got %h want 00004a4a", i, DataOut);
            end
        end
        drive(1'b1, 32'h0000_8D9C, 4'b0000);
        n_tests++;
        if (DataOut !== 32'h0000_3311) begin
            n_fail++;
            $display("FAIL ts_after got %h want 00003311", DataOut);
        end
        drive(1'b0, 32'h0, 4'b0000);
    endtask

    task automatic test_com_mid_ts();
        logic [7:0] st [10] = '{8'hBC, 8'h4A, 8'h4A, 8'h4A, 8'h4A, 8'h4A, 8'hBC, 8'h3C, 8'hB2, 8'hFC};
        logic       kk [10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [7:0] ex [10] = '{8'hBC, 8'h4A, 8'h4A, 8'h4A, 8'h4A, 8'h4A, 8'hBC, 8'h3C, 8'hA5, 8'h3C};
        pipewidth = 6'd8;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, {24'h0, st[i]}, {3'b000, kk[i]});
            n_tests++;
            if (DataOut !== {24'h0, ex[i]}) begin
                n_fail++;
                $display("FAIL mid_ts[%0d] got %h want %h", i, DataOut, {24'h0, ex[i]});
            end
        end
        drive(1'b0, 32'h0, 4'b0000);
    endtask

    task automatic test_turnoff_stall();
        // Columns: valid, turnOff, K, symbol, expected output symbol.
        logic       vv [12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic       tt [12] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic       kk [12] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [7:0] st [12] = '{8'hBC, 8'h3C, 8'h17, 8'hC0, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h90};
        logic [7:0] ex [12] = '{8'hBC, 8'h3C, 8'h17, 8'hC0, 8'h00, 8'h00, 8'h00, 8'h11, 8'h00, 8'h00, 8'h00, 8'h22};
        logic [7:0] sym;
        pipewidth = 6'd8;
        for (int i = 0; i < 12; i++) begin
            turnOff = tt[i];
            sym     = vv[i] ? st[i] : 8'($urandom);
            drive(vv[i], {24'h0, sym}, {3'b000, kk[i]});
            n_tests++;
            if (DataValidOut !== vv[i] || DataOut !== {24'h0, ex[i]} ||
                DataKOut !== {3'b000, kk[i] & vv[i]}) begin
                n_fail++;
                $display("FAIL turnoff[%0d] got v=%b d=%h k=%b want v=%b d=%h k=%b", i,
                         DataValidOut, DataOut, DataKOut, vv[i], {24'h0, ex[i]},
                         {3'b000, kk[i] & vv[i]});
            end
        end
        turnOff = 1'b0;
        drive(1'b0, 32'h0, 4'b0000);
    endtask

    initial begin
        reset       = 1'b1;
        turnOff     = 1'b0;
        pipewidth   = 6'd8;
        RxData      = '0;
        RxDataK     = '0;
        RxDataValid = 1'b0;
        test_reset();
        test_known_pw8();
        test_skp_pw32();
        test_ts1_pw16();
        test_com_mid_ts();
        test_turnoff_stall();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
